// File: rtl/sonar_controlador_varredura.sv
// Sweep sequencer for the sonar: steps the servo in a ping-pong sweep and, at each
// position, waits for settle, triggers one distance measurement and sends the result bytes.
module sonar_controlador_varredura #(
  parameter int N_POS       = 8,
  parameter int N_BYTES     = 8,
  parameter int T_POSICIONA = 100000000,
  parameter int T_TIMEOUT   = 50000000,
  localparam int PW   = (N_POS > 1) ? $clog2(N_POS) : 1,
  localparam int SW   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1,
  localparam int TMAX = (T_POSICIONA > T_TIMEOUT) ? T_POSICIONA : T_TIMEOUT,
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          ligar_i,
  input  logic          pronto_medida_i,
  input  logic          pronto_tx_i,
  output logic          medir_o,
  output logic          transmite_o,
  output logic [SW-1:0] sel_byte_o,
  output logic [PW-1:0] posicao_o,
  output logic          timeout_o,
  output logic          fim_posicao_o,
  output logic [3:0]    db_estado_o
);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    POSICIONA      = 4'd1,
    MEDE           = 4'd2,
    AGUARDA_MEDIDA = 4'd3,
    TRANSMITE      = 4'd4,
    AGUARDA_TX     = 4'd5,
    PROXIMA        = 4'd6
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          desce_q, desce_d;
  logic          timeout_q, timeout_d;
  logic          medir_q, transmite_q, fim_q;

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    pos_d     = pos_q;
    desce_d   = desce_q;
    timeout_d = timeout_q;
    case (estado_q)
      INICIAL: begin
        if (ligar_i) begin
          estado_d  = POSICIONA;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end
      POSICIONA: begin
        if (cnt_q == CW'(T_POSICIONA - 1)) estado_d = MEDE;
        else cnt_d = cnt_q + CW'(1);
      end
      MEDE: begin
        cnt_d    = '0;
        estado_d = AGUARDA_MEDIDA;
      end
      AGUARDA_MEDIDA: begin
        // a measurement arriving on the terminal cycle beats the timeout
        if (pronto_medida_i) begin
          estado_d = TRANSMITE;
          sel_d    = '0;
        end else if (cnt_q == CW'(T_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          estado_d  = TRANSMITE;
          sel_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRANSMITE: estado_d = AGUARDA_TX;
      AGUARDA_TX: begin
        if (pronto_tx_i) begin
          if (sel_q == SW'(N_BYTES - 1)) begin
            estado_d = PROXIMA;
            sel_d    = '0;
          end else begin
            estado_d = TRANSMITE;
            sel_d    = sel_q + SW'(1);
          end
        end
      end
      PROXIMA: begin
        sel_d = '0;
        if (!desce_q) begin
          if (pos_q == PW'(N_POS - 1)) begin
            desce_d = 1'b1;
            pos_d   = pos_q - PW'(1);
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else begin
          if (pos_q == '0) begin
            desce_d = 1'b0;
            pos_d   = pos_q + PW'(1);
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
        if (ligar_i) begin
          estado_d = POSICIONA;
          cnt_d    = '0;
        end else begin
          estado_d = INICIAL;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  // pulse outputs are flopped from the next state so they line up with the state they belong to
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      estado_q    <= INICIAL;
      cnt_q       <= '0;
      sel_q       <= '0;
      pos_q       <= '0;
      desce_q     <= 1'b0;
      timeout_q   <= 1'b0;
      medir_q     <= 1'b0;
      transmite_q <= 1'b0;
      fim_q       <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      pos_q       <= pos_d;
      desce_q     <= desce_d;
      timeout_q   <= timeout_d;
      medir_q     <= (estado_d == MEDE);
      transmite_q <= (estado_d == TRANSMITE);
      fim_q       <= (estado_d == PROXIMA);
    end
  end

  assign medir_o       = medir_q;
  assign transmite_o   = transmite_q;
  assign fim_posicao_o = fim_q;
  assign sel_byte_o    = sel_q;
  assign posicao_o     = pos_q;
  assign timeout_o     = timeout_q;
  assign db_estado_o   = estado_q;

endmodule
